seconds_tick_counter: RTL and testbench

Seconds stage of the timer datapath in the VGA monitor design. Divides the system clock down to a 1 Hz tick and keeps a 0–59 seconds count, either counting up (stopwatch) or down (countdown timer). Produces the `seconds` value and a one-cycle minute carry/borrow that drive the downstream minutes counter. Asserts `finish` when a countdown reaches 00:00. Everything runs in a single clock domain. The downstream minutes counter samples the carry/borrow pulses synchronously on `clk`.

---
 rtl/seconds_tick_counter.sv | 159 +++++++++++++++
 tb/tb_seconds_tick_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seconds_tick_counter.sv
// seconds_tick_counter
//   Seconds stage of the timer datapath. A prescaler divides clk down to a
//   1 Hz tick; each tick moves a 0..59 seconds count up (stopwatch) or down
//   (countdown). Emits one-cycle minute carry/borrow pulses for the minutes
//   counter and a level finish flag once a countdown reaches 00:00.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   enable        in   1 = run, 0 = pause (count and prescaler hold)
//   forward       in   1 = count up, 0 = count down
//   clear         in   synchronous clear of count and prescaler
//   load          in   synchronous preset of seconds from load_value
//   load_value    in   [5:0] preset, saturates at 59
//   minutes_zero  in   minutes counter is at 0
//   seconds       out  [5:0] current count, 0..59
//   tick          out  one-cycle pulse per prescaler wrap
//   minute_carry  out  one-cycle pulse on 59 -> 0 while counting up
//   minute_borrow out  one-cycle pulse on 0 -> 59 while counting down
//   finish        out  level, countdown has reached 00:00
module seconds_tick_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       forward,
    input  logic       clear,
    input  logic       load,
    input  logic [5:0] load_value,
    input  logic       minutes_zero,
    output logic [5:0] seconds,
    output logic       tick,
    output logic       minute_carry,
    output logic       minute_borrow,
    output logic       finish
);

    localparam int             PW   = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  TERM = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_UP   = 2'd1,
        S_RUN_DOWN = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [5:0]    r_sec;
    logic          r_tick;
    logic          r_carry;
    logic          r_borrow;
    logic          r_finish;

    state_t        w_state_nxt;
    logic [PW-1:0] w_pre_nxt;
    logic [5:0]    w_sec_nxt;
    logic          w_tick_nxt;
    logic          w_carry_nxt;
    logic          w_borrow_nxt;
    logic          w_finish_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pre    <= '0;
            r_sec    <= '0;
            r_tick   <= 1'b0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pre    <= w_pre_nxt;
            r_sec    <= w_sec_nxt;
            r_tick   <= w_tick_nxt;
            r_carry  <= w_carry_nxt;
            r_borrow <= w_borrow_nxt;
            r_finish <= w_finish_nxt;
        end
    end

    // The run/direction decision uses enable/forward directly rather than the
    // registered state, so the prescaler counts on the very edge enable is
    // first seen: a tick lands exactly CLK_HZ edges after enable from 0, and
    // a resume from prescaler=p ticks CLK_HZ-p edges later.
    always_comb begin
        w_state_nxt  = r_state;
        w_pre_nxt    = r_pre;
        w_sec_nxt    = r_sec;
        w_tick_nxt   = 1'b0;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        w_finish_nxt = r_finish;

        if (clear) begin
            w_state_nxt  = S_IDLE;
            w_pre_nxt    = '0;
            w_sec_nxt    = '0;
            w_finish_nxt = 1'b0;
        end else if (load) begin
            w_state_nxt  = S_IDLE;
            w_pre_nxt    = '0;
            w_sec_nxt    = (load_value > 6'd59) ? 6'd59 : load_value;
            w_finish_nxt = 1'b0;
        end else if (r_state == S_DONE) begin
            // frozen until clear/load
        end else if (!enable) begin
            w_state_nxt = S_IDLE;
        end else if (!forward && r_state != S_RUN_DOWN &&
                     r_sec == 6'd0 && minutes_zero) begin
            // starting a countdown that is already at 00:00
            w_state_nxt  = S_DONE;
            w_finish_nxt = 1'b1;
        end else begin
            w_state_nxt = forward ? S_RUN_UP : S_RUN_DOWN;
            if (r_pre == TERM) begin
                w_pre_nxt  = '0;
                w_tick_nxt = 1'b1;
                if (forward) begin
                    if (r_sec == 6'd59) begin
                        w_sec_nxt   = 6'd0;
                        w_carry_nxt = 1'b1;
                    end else begin
                        w_sec_nxt = r_sec + 6'd1;
                    end
                end else if (r_sec == 6'd0) begin
                    if (!minutes_zero) begin
                        w_sec_nxt    = 6'd59;
                        w_borrow_nxt = 1'b1;
                    end else begin
                        // minutes dropped to 0 while sitting at :00; stop
                        // rather than wrap below zero
                        w_tick_nxt   = 1'b0;
                        w_state_nxt  = S_DONE;
                        w_finish_nxt = 1'b1;
                    end
                end else if (r_sec == 6'd1 && minutes_zero) begin
                    w_sec_nxt    = 6'd0;
                    w_state_nxt  = S_DONE;
                    w_finish_nxt = 1'b1;
                end else begin
                    w_sec_nxt = r_sec - 6'd1;
                end
            end else begin
                w_pre_nxt = r_pre + PW'(1);
            end
        end
    end

    assign seconds       = r_sec;
    assign tick          = r_tick;
    assign minute_carry  = r_carry;
    assign minute_borrow = r_borrow;
    assign finish        = r_finish;

endmodule

// File: tb/tb_seconds_tick_counter.sv
module tb_seconds_tick_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       forward;
    logic       clear;
    logic       load;
    logic [5:0] load_value;
    logic       minutes_zero;
    logic [5:0] seconds;
    logic       tick;
    logic       minute_carry;
    logic       minute_borrow;
    logic       finish;

    int checks = 0;
    int errors = 0;
    int bad;

    seconds_tick_counter #(.CLK_HZ(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .forward      (forward),
        .clear        (clear),
        .load         (load),
        .load_value   (load_value),
        .minutes_zero (minutes_zero),
        .seconds      (seconds),
        .tick         (tick),
        .minute_carry (minute_carry),
        .minute_borrow(minute_borrow),
        .finish       (finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; forward = 1'b1; clear = 1'b0;
        load = 1'b0; load_value = 6'd0; minutes_zero = 1'b0;

        // 1. reset values
        #2 reset = 1'b0;
        #1;
        chk("rst_sec",    seconds,       0);
        chk("rst_tick",   tick,          0);
        chk("rst_carry",  minute_carry,  0);
        chk("rst_borrow", minute_borrow, 0);
        chk("rst_finish", finish,        0);
        step(3);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (seconds != 0 || tick || minute_carry || minute_borrow || finish) bad++;
        end
        chk("rst_hold", bad, 0);

        // 2. up-count with carry
        load = 1'b1; load_value = 6'd58;
        step(1);
        chk("load58", seconds, 58);
        load = 1'b0; enable = 1'b1; forward = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("up_tick",  tick,          int'(k % 4 == 0));
            chk("up_carry", minute_carry,  int'(k == 8));
            chk("up_sec",   seconds,       (k < 4) ? 58 : (k < 8) ? 59 : 0);
        end

        // 3. down-count with borrow, then finish
        enable = 1'b0; forward = 1'b0; minutes_zero = 1'b0;
        load = 1'b1; load_value = 6'd0;
        step(1);
        load = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("dn_tick",   tick,          int'(k == 4));
            chk("dn_borrow", minute_borrow, int'(k == 4));
            chk("dn_sec",    seconds,       (k < 4) ? 0 : 59);
        end
        minutes_zero = 1'b1; load = 1'b1; load_value = 6'd2;
        step(1);
        chk("load2",      seconds, 2);
        chk("load2_fin",  finish,  0);
        load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("fin_tick", tick,    int'(k % 4 == 0));
            chk("fin_sec",  seconds, (k < 4) ? 2 : (k < 8) ? 1 : 0);
            chk("fin_flag", finish,  int'(k == 8));
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (seconds != 0 || tick || minute_carry || minute_borrow || !finish) bad++;
        end
        chk("done_hold", bad, 0);

        // 6. asynchronous reset while in DONE
        reset = 1'b0;
        #1;
        chk("arst_finish", finish,  0);
        chk("arst_sec",    seconds, 0);
        step(1);
        enable = 1'b0; reset = 1'b1;
        step(2);
        chk("arst_state",  int'(dut.r_state), 0);
        chk("arst_fin2",   finish, 0);
        chk("arst_tick",   tick,   0);

        // 4. pause/resume and direction change
        minutes_zero = 1'b0;
        load = 1'b1; load_value = 6'd10;
        step(1);
        load = 1'b0; forward = 1'b1; enable = 1'b1;
        step(2);
        chk("pre2_sec", seconds, 10);
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (seconds != 10 || tick) bad++;
        end
        chk("pause_hold", bad, 0);
        chk("pause_pre",  int'(dut.r_pre), 2);
        enable = 1'b1;
        step(1);
        chk("resume_t1", tick, 0);
        step(1);
        chk("resume_t2", tick,    1);
        chk("resume_up", seconds, 11);
        step(1);
        forward = 1'b0;
        step(2);
        chk("dir_notick", tick, 0);
        step(1);
        chk("dir_tick",   tick,          1);
        chk("dir_dec",    seconds,       10);
        chk("dir_borrow", minute_borrow, 0);

        // 5. priority and saturation
        enable = 1'b0;
        load = 1'b1; load_value = 6'd63;
        step(1);
        chk("sat63", seconds, 59);
        clear = 1'b1; load = 1'b1; load_value = 6'd20;
        step(1);
        chk("clr_ld_sec",   seconds, 0);
        chk("clr_ld_state", int'(dut.r_state), 0);
        clear = 1'b0;
        load_value = 6'd5;
        step(1);
        load = 1'b0; forward = 1'b1; enable = 1'b1;
        step(3);
        chk("pretick_sec", seconds, 5);
        chk("pretick_t",   tick,    0);
        clear = 1'b1;
        step(1);
        chk("clr_tick_sec",   seconds,      0);
        chk("clr_tick_t",     tick,         0);
        chk("clr_tick_carry", minute_carry, 0);
        clear = 1'b0;
        step(3);
        chk("post_clr_t0", tick, 0);
        step(1);
        chk("post_clr_t1", tick,    1);
        chk("post_clr_s",  seconds, 1);

        // countdown started already at 00:00
        clear = 1'b1; enable = 1'b0;
        step(1);
        clear = 1'b0; minutes_zero = 1'b1; forward = 1'b0; enable = 1'b1;
        step(1);
        chk("zero_fin",   finish,  1);
        chk("zero_tick",  tick,    0);
        chk("zero_sec",   seconds, 0);
        chk("zero_state", int'(dut.r_state), 3);
        load = 1'b1; load_value = 6'd7;
        step(1);
        chk("ld_fin_fall", finish,  0);
        chk("ld_sec7",     seconds, 7);
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
